// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: opcodes, ALU codes,
// sequencer states, instruction classes and the strobe bundle.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // ALU codes reuse the instruction opcodes; INC sits in unused space
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_INC = 5'd31;

    typedef enum logic [3:0] {
        RESET_ST,
        FETCH0,
        FETCH1,
        FETCH2,
        T3,
        T4,
        T5,
        T6,
        T7,
        PAUSED,
        HALTED
    } state_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_ALU3,
        C_IMM,
        C_UNARY,
        C_LD,
        C_LDI,
        C_ST,
        C_MULDIV,
        C_BR,
        C_JR,
        C_JAL,
        C_MFHI,
        C_MFLO,
        C_IN,
        C_OUT,
        C_HALT
    } cls_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic rd;
        logic wr;
        logic y_in;
        logic z_in;
        logic zhi_out;
        logic zlo_out;
        logic hi_in;
        logic hi_out;
        logic lo_in;
        logic lo_out;
        logic c_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic con_in;
        logic outport_in;
        logic inport_out;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode to instruction-class map; unknown opcodes fall
// through to the nop class.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls
);

    // pure combinational opcode classification
    always_comb begin
        cls = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:         cls = C_IMM;
            OP_NEG, OP_NOT:                   cls = C_UNARY;
            OP_LD:                            cls = C_LD;
            OP_LDI:                           cls = C_LDI;
            OP_ST:                            cls = C_ST;
            OP_MUL, OP_DIV:                   cls = C_MULDIV;
            OP_BR:                            cls = C_BR;
            OP_JR:                            cls = C_JR;
            OP_JAL:                           cls = C_JAL;
            OP_MFHI:                          cls = C_MFHI;
            OP_MFLO:                          cls = C_MFLO;
            OP_IN:                            cls = C_IN;
            OP_OUT:                           cls = C_OUT;
            OP_HALT:                          cls = C_HALT;
            default:                          cls = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle sequencer: fetch, per-class execute
// steps, memory wait stretching, pause and halt handling.
module control_unit
    import cu_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CONin,
    output logic        OutportIn,
    output logic        InPortout,
    output logic [4:0]  OpCode,
    output logic        Run
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state;
    state_t     state_n;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_n;
    logic       wait_done;
    logic       fin;
    logic       run;
    logic [4:0] op;
    logic [4:0] ir_op;
    cls_t       cls;
    ctrl_t      c;
    logic       unused_ir;

    assign ir_op     = IR[31:27];
    assign unused_ir = ^IR[26:0];
    assign wait_done = (wait_cnt == WAIT_LAST);

    // IR is only stable from T3 on, so the class drives execute states
    cu_decode u_decode (
        .opcode (ir_op),
        .cls    (cls)
    );

    // state and memory wait counter registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= RESET_ST;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // next-state and Moore strobe decode
    always_comb begin
        c          = '0;
        op         = '0;
        run        = 1'b1;
        fin        = 1'b0;
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            RESET_ST: state_n = FETCH0;
            FETCH0: begin
                c.pc_out = 1'b1;
                c.mar_in = 1'b1;
                c.z_in   = 1'b1;
                op       = ALU_INC;
                state_n  = FETCH1;
            end
            FETCH1: begin
                c.zlo_out = 1'b1;
                c.pc_in   = 1'b1;
                c.rd      = 1'b1;
                if (wait_done) begin
                    c.mdr_in   = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = FETCH2;
                end else begin
                    wait_cnt_n = wait_cnt + 3'd1;
                end
            end
            FETCH2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
                state_n   = T3;
            end
            T3: begin
                state_n = T4;
                case (cls)
                    C_ALU3, C_IMM: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    C_UNARY: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ir_op;
                    end
                    C_LD, C_LDI, C_ST: begin
                        c.grb    = 1'b1;
                        c.ba_out = 1'b1;
                        c.y_in   = 1'b1;
                    end
                    C_MULDIV: begin
                        c.gra   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    C_BR: begin
                        c.gra    = 1'b1;
                        c.r_out  = 1'b1;
                        c.con_in = 1'b1;
                    end
                    C_JR: begin
                        c.gra   = 1'b1;
                        c.r_out = 1'b1;
                        c.pc_in = 1'b1;
                        fin     = 1'b1;
                    end
                    C_JAL: begin
                        c.pc_out = 1'b1;
                        c.grb    = 1'b1;
                        c.r_in   = 1'b1;
                    end
                    C_MFHI: begin
                        c.hi_out = 1'b1;
                        c.gra    = 1'b1;
                        c.r_in   = 1'b1;
                        fin      = 1'b1;
                    end
                    C_MFLO: begin
                        c.lo_out = 1'b1;
                        c.gra    = 1'b1;
                        c.r_in   = 1'b1;
                        fin      = 1'b1;
                    end
                    C_IN: begin
                        c.inport_out = 1'b1;
                        c.gra        = 1'b1;
                        c.r_in       = 1'b1;
                        fin          = 1'b1;
                    end
                    C_OUT: begin
                        c.gra        = 1'b1;
                        c.r_out      = 1'b1;
                        c.outport_in = 1'b1;
                        fin          = 1'b1;
                    end
                    C_HALT:  state_n = HALTED;
                    default: fin     = 1'b1;
                endcase
            end
            T4: begin
                state_n = T5;
                case (cls)
                    C_ALU3: begin
                        c.grc   = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ir_op;
                    end
                    C_IMM: begin
                        c.c_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ir_op;
                    end
                    C_UNARY: begin
                        c.zlo_out = 1'b1;
                        c.gra     = 1'b1;
                        c.r_in    = 1'b1;
                        fin       = 1'b1;
                    end
                    C_LD, C_LDI, C_ST: begin
                        c.c_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ALU_ADD;
                    end
                    C_MULDIV: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ir_op;
                    end
                    C_BR: begin
                        c.pc_out = 1'b1;
                        c.y_in   = 1'b1;
                    end
                    C_JAL: begin
                        c.gra   = 1'b1;
                        c.r_out = 1'b1;
                        c.pc_in = 1'b1;
                        fin     = 1'b1;
                    end
                    default: fin = 1'b1;
                endcase
            end
            T5: begin
                state_n = T6;
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin
                        c.zlo_out = 1'b1;
                        c.gra     = 1'b1;
                        c.r_in    = 1'b1;
                        fin       = 1'b1;
                    end
                    C_LD, C_ST: begin
                        c.zlo_out = 1'b1;
                        c.mar_in  = 1'b1;
                    end
                    C_MULDIV: begin
                        c.zlo_out = 1'b1;
                        c.lo_in   = 1'b1;
                    end
                    C_BR: begin
                        c.c_out = 1'b1;
                        c.z_in  = 1'b1;
                        op      = ALU_ADD;
                    end
                    default: fin = 1'b1;
                endcase
            end
            T6: begin
                state_n = T7;
                case (cls)
                    C_LD: begin
                        c.rd = 1'b1;
                        if (wait_done) begin
                            c.mdr_in   = 1'b1;
                            wait_cnt_n = '0;
                        end else begin
                            wait_cnt_n = wait_cnt + 3'd1;
                            state_n    = T6;
                        end
                    end
                    C_ST: begin
                        c.gra    = 1'b1;
                        c.r_out  = 1'b1;
                        c.mdr_in = 1'b1;
                    end
                    C_MULDIV: begin
                        c.zhi_out = 1'b1;
                        c.hi_in   = 1'b1;
                        fin       = 1'b1;
                    end
                    C_BR: begin
                        c.zlo_out = 1'b1;
                        c.pc_in   = CON_FF;
                        fin       = 1'b1;
                    end
                    default: fin = 1'b1;
                endcase
            end
            T7: begin
                case (cls)
                    C_LD: begin
                        c.mdr_out = 1'b1;
                        c.gra     = 1'b1;
                        c.r_in    = 1'b1;
                        fin       = 1'b1;
                    end
                    C_ST: begin
                        c.wr = 1'b1;
                        if (wait_done) begin
                            wait_cnt_n = '0;
                            fin        = 1'b1;
                        end else begin
                            wait_cnt_n = wait_cnt + 3'd1;
                        end
                    end
                    default: fin = 1'b1;
                endcase
            end
            PAUSED: begin
                run = 1'b0;
                if (!Stop) state_n = FETCH0;
            end
            HALTED:  run     = 1'b0;
            default: state_n = RESET_ST;
        endcase
        if (fin) state_n = Stop ? PAUSED : FETCH0;
    end

    assign PCout     = c.pc_out;
    assign PCin      = c.pc_in;
    assign IRin      = c.ir_in;
    assign MARin     = c.mar_in;
    assign MDRin     = c.mdr_in;
    assign MDRout    = c.mdr_out;
    assign Read      = c.rd;
    assign Write     = c.wr;
    assign Yin       = c.y_in;
    assign Zin       = c.z_in;
    assign Zhighout  = c.zhi_out;
    assign Zlowout   = c.zlo_out;
    assign HIin      = c.hi_in;
    assign HIout     = c.hi_out;
    assign LOin      = c.lo_in;
    assign LOout     = c.lo_out;
    assign Cout      = c.c_out;
    assign Gra       = c.gra;
    assign Grb       = c.grb;
    assign Grc       = c.grc;
    assign Rin       = c.r_in;
    assign Rout      = c.r_out;
    assign BAout     = c.ba_out;
    assign CONin     = c.con_in;
    assign OutportIn = c.outport_in;
    assign InPortout = c.inport_out;
    assign OpCode    = op;
    assign Run       = run;

endmodule
